// File: rtl/grabador_notas.sv
// Note recorder/player sitting between the keypad and the tone generator.
// Live keys pass through; RECORD stores run-length {mask, duration} entries, PLAY replays them.
module grabador_notas #(
    parameter int TICK_DIV = 250000,
    parameter int ADDR_W   = 8,
    parameter int DUR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        btn_in,
    input  logic              rec_req,
    input  logic              play_req,
    output logic [6:0]        btn_out,
    output logic              recording,
    output logic              playing,
    output logic              mem_full,
    output logic [ADDR_W:0]   rec_len
);

    localparam int KEYS  = 7;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ENT_W = KEYS + DUR_W;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    function automatic logic dur_saturated(input logic [DUR_W-1:0] d);
        return d == DUR_MAX;
    endfunction

    function automatic logic [DUR_W-1:0] dur_inc(input logic [DUR_W-1:0] d);
        return dur_saturated(d) ? d : d + DUR_ONE;
    endfunction

    logic [6:0]        sync1_q, sync1_d;
    logic [6:0]        sync2_q, sync2_d;
    logic [6:0]        btn_out_q, btn_out_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              mem_full_q, mem_full_d;
    logic              run_open_q, run_open_d;
    logic [6:0]        run_mask_q, run_mask_d;
    logic [DUR_W-1:0]  run_dur_q, run_dur_d;
    logic [ADDR_W-1:0] play_ptr_q, play_ptr_d;
    logic [DUR_W-1:0]  play_elap_q, play_elap_d;
    logic              play_vld_q, play_vld_d;
    logic              recording_q, recording_d;
    logic              playing_q, playing_d;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  mem_rd_q;

    logic              tick;
    logic [6:0]        key_mask;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ENT_W-1:0]  wr_data;
    logic [6:0]        cur_mask;
    logic [DUR_W-1:0]  cur_dur;
    logic [ADDR_W:0]   next_ptr;

    assign tick     = (tick_cnt_q == TICK_LAST);
    assign key_mask = ~sync2_q;
    assign wr_addr  = rec_len_q[ADDR_W-1:0];
    assign wr_data  = {run_mask_q, run_dur_q};
    assign cur_mask = mem_rd_q[ENT_W-1:DUR_W];
    assign cur_dur  = mem_rd_q[DUR_W-1:0];
    assign next_ptr = {1'b0, play_ptr_q} + LEN_ONE;

    always_comb begin
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CNT_W'(1);
        rec_len_d   = rec_len_q;
        mem_full_d  = mem_full_q;
        run_open_d  = run_open_q;
        run_mask_d  = run_mask_q;
        run_dur_d   = run_dur_q;
        play_ptr_d  = play_ptr_q;
        play_elap_d = play_elap_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rec_req) begin
                    state_d    = ST_REC;
                    tick_cnt_d = '0;
                    rec_len_d  = '0;
                    mem_full_d = 1'b0;
                    run_open_d = 1'b0;
                end else if (play_req && rec_len_q != '0) begin
                    state_d     = ST_PLAY;
                    tick_cnt_d  = '0;
                    play_ptr_d  = '0;
                    play_elap_d = '0;
                end
            end

            ST_REC: begin
                // A stop request takes priority over a tick landing in the same cycle.
                if (rec_req) begin
                    state_d    = ST_IDLE;
                    run_open_d = 1'b0;
                    if (run_open_q) begin
                        wr_en     = 1'b1;
                        rec_len_d = rec_len_q + LEN_ONE;
                        if (rec_len_q == LAST_ADDR) begin
                            mem_full_d = 1'b1;
                        end
                    end
                end else if (tick) begin
                    if (!run_open_q) begin
                        run_open_d = 1'b1;
                        run_mask_d = key_mask;
                        run_dur_d  = DUR_ONE;
                    end else if (key_mask == run_mask_q && !dur_saturated(run_dur_q)) begin
                        run_dur_d = dur_inc(run_dur_q);
                    end else begin
                        wr_en     = 1'b1;
                        rec_len_d = rec_len_q + LEN_ONE;
                        if (rec_len_q == LAST_ADDR) begin
                            state_d    = ST_IDLE;
                            mem_full_d = 1'b1;
                            run_open_d = 1'b0;
                        end else begin
                            run_mask_d = key_mask;
                            run_dur_d  = DUR_ONE;
                        end
                    end
                end
            end

            ST_PLAY: begin
                // Ticks decide entry changes; btn_out follows two cycles later through
                // the memory read and output register, so every entry keeps its full length.
                if (play_req) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (play_elap_q + DUR_ONE == cur_dur) begin
                        play_elap_d = '0;
                        if (next_ptr == rec_len_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            play_ptr_d = next_ptr[ADDR_W-1:0];
                        end
                    end else begin
                        play_elap_d = play_elap_q + DUR_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        play_vld_d  = (state_q == ST_PLAY);
        btn_out_d   = play_vld_q ? ~cur_mask : sync2_q;
        recording_d = (state_d == ST_REC);
        playing_d   = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 7'h7F;
            sync2_q     <= 7'h7F;
            btn_out_q   <= 7'h7F;
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            rec_len_q   <= '0;
            mem_full_q  <= 1'b0;
            run_open_q  <= 1'b0;
            play_ptr_q  <= '0;
            play_elap_q <= '0;
            play_vld_q  <= 1'b0;
            recording_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            btn_out_q   <= btn_out_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            rec_len_q   <= rec_len_d;
            mem_full_q  <= mem_full_d;
            run_open_q  <= run_open_d;
            play_ptr_q  <= play_ptr_d;
            play_elap_q <= play_elap_d;
            play_vld_q  <= play_vld_d;
            recording_q <= recording_d;
            playing_q   <= playing_d;
        end
    end

    // Run payload and memory carry no reset; run_open_q / play_vld_q gate their use.
    always_ff @(posedge clk) begin
        run_mask_q <= run_mask_d;
        run_dur_q  <= run_dur_d;
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        mem_rd_q <= mem[play_ptr_q];
    end

    assign btn_out   = btn_out_q;
    assign recording = recording_q;
    assign playing   = playing_q;
    assign mem_full  = mem_full_q;
    assign rec_len   = rec_len_q;

endmodule

// File: tb/tb_grabador_notas.sv
// Bench for grabador_notas with a short tick and a tiny memory so every corner is reachable.
// btn_out is checked cycle by cycle from a queue of expected values pushed when stimulus is driven.
module tb_grabador_notas;

    localparam int TD = 4;
    localparam int AW = 2;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    btn_in = 7'h7F;
    logic          rec_req = 1'b0;
    logic          play_req = 1'b0;
    logic [6:0]    btn_out;
    logic          recording;
    logic          playing;
    logic          mem_full;
    logic [AW:0]   rec_len;

    grabador_notas #(.TICK_DIV(TD), .ADDR_W(AW), .DUR_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .rec_req   (rec_req),
        .play_req  (play_req),
        .btn_out   (btn_out),
        .recording (recording),
        .playing   (playing),
        .mem_full  (mem_full),
        .rec_len   (rec_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         due;
        logic [6:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [6:0] btn;
        logic [6:0] exp;
    } pt_vec_t;

    logic [6:0] pats [8];
    logic [6:0] exp_mask [4];
    int         exp_dur [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int due, input logic [6:0] exp);
        sb_t e;
        e.due = due;
        e.exp = exp;
        sbq.push_back(e);
    endfunction

    always @(negedge clk) begin : monitor
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            n_tests++;
            if (e.due != cyc || btn_out !== e.exp) begin
                n_fail++;
                $display("FAIL btn_out@%0d: got %0h, expected %0h (checked at cycle %0d)",
                         e.due, btn_out, e.exp, cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts recording, presents one pattern per tick, optionally stops afterwards.
    task automatic record(input int n, input bit stop);
        rec_req = 1'b1;
        step(1);
        rec_req = 1'b0;
        chk("rec_enter", recording, 1'b1);
        for (int m = 0; m < n; m++) begin
            btn_in = pats[m];
            step(TD);
        end
        btn_in = 7'h7F;
        if (stop) begin
            rec_req = 1'b1;
            step(1);
            rec_req = 1'b0;
        end
        step(3);
    endtask

    // Plays back and schedules the full expected btn_out waveform.
    task automatic play_check(input int n, input string tag);
        int k;
        int c;
        int tot;
        k   = cyc;
        tot = 0;
        play_req = 1'b1;
        push(k + 1, 7'h7F);
        push(k + 2, 7'h7F);
        c = k + 3;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < exp_dur[i] * TD; j++) begin
                push(c, ~exp_mask[i]);
                c++;
            end
            tot += exp_dur[i];
        end
        push(c, 7'h7F);
        push(c + 1, 7'h7F);
        step(1);
        play_req = 1'b0;
        chk({tag, "_playing_start"}, playing, 1'b1);
        step(tot * TD - 1);
        chk({tag, "_playing_last"}, playing, 1'b1);
        step(1);
        chk({tag, "_playing_end"}, playing, 1'b0);
        step(4);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        pt_vec_t pt [6];
        logic [6:0] prev;
        int k;

        pt[0] = '{btn: 7'h7E, exp: 7'h7E};
        pt[1] = '{btn: 7'h7F, exp: 7'h7F};
        pt[2] = '{btn: 7'h3F, exp: 7'h3F};
        pt[3] = '{btn: 7'h00, exp: 7'h00};
        pt[4] = '{btn: 7'h55, exp: 7'h55};
        pt[5] = '{btn: 7'h7F, exp: 7'h7F};

        step(3);
        rst_n = 1'b1;
        step(2);
        chk("rst_btn_out", btn_out, 7'h7F);
        chk("rst_recording", recording, 1'b0);
        chk("rst_playing", playing, 1'b0);
        chk("rst_mem_full", mem_full, 1'b0);
        chk("rst_rec_len", rec_len, 0);

        // Passthrough: old value still visible 2 clk after the change, new value at 3 clk.
        prev = 7'h7F;
        for (int i = 0; i < 6; i++) begin
            btn_in = pt[i].btn;
            push(cyc + 2, prev);
            push(cyc + 3, pt[i].exp);
            prev = pt[i].exp;
            step(4);
        end

        // Do held 3 ticks, silence 2 ticks.
        pats[0] = 7'h7E; pats[1] = 7'h7E; pats[2] = 7'h7E; pats[3] = 7'h7F; pats[4] = 7'h7F;
        record(5, 1'b1);
        chk("rec3_recording", recording, 1'b0);
        chk("rec3_rec_len", rec_len, 2);
        chk("rec3_mem_full", mem_full, 1'b0);
        exp_mask = '{7'h01, 7'h00, 7'h00, 7'h00};
        exp_dur  = '{3, 2, 0, 0};
        play_check(2, "play3");
        play_check(2, "replay3");
        chk("replay3_rec_len", rec_len, 2);

        // rec_req ignored during PLAY, then play_req aborts.
        k = cyc;
        play_req = 1'b1;
        push(k + 1, 7'h7F);
        push(k + 2, 7'h7F);
        for (int c = k + 3; c <= k + 9; c++) push(c, 7'h7E);
        push(k + 10, 7'h7F);
        push(k + 11, 7'h7F);
        step(1);
        play_req = 1'b0;
        step(3);
        rec_req = 1'b1;
        step(1);
        rec_req = 1'b0;
        chk("play_rec_ignored_recording", recording, 1'b0);
        chk("play_rec_ignored_playing", playing, 1'b1);
        step(2);
        play_req = 1'b1;
        step(1);
        play_req = 1'b0;
        chk("abort_playing", playing, 1'b0);
        chk("abort_rec_len", rec_len, 2);
        step(5);

        // Duration saturation: Fa held 5 ticks with a 2-bit duration.
        for (int i = 0; i < 5; i++) pats[i] = 7'h77;
        record(5, 1'b1);
        chk("sat_rec_len", rec_len, 2);
        chk("sat_entry0", dut.mem[0], {7'h08, 2'd3});
        chk("sat_entry1", dut.mem[1], {7'h08, 2'd2});
        exp_mask = '{7'h08, 7'h08, 7'h00, 7'h00};
        exp_dur  = '{3, 2, 0, 0};
        play_check(2, "play_sat");

        // Memory fill: a new key every tick, recording ends by itself.
        pats[0] = 7'h7E; pats[1] = 7'h7D; pats[2] = 7'h7B; pats[3] = 7'h77; pats[4] = 7'h6F;
        record(5, 1'b0);
        chk("full_recording", recording, 1'b0);
        chk("full_mem_full", mem_full, 1'b1);
        chk("full_rec_len", rec_len, 4);
        exp_mask = '{7'h01, 7'h02, 7'h04, 7'h08};
        exp_dur  = '{1, 1, 1, 1};
        play_check(4, "play_full");

        // rec_req and play_req together: record wins.
        rec_req  = 1'b1;
        play_req = 1'b1;
        step(1);
        rec_req  = 1'b0;
        play_req = 1'b0;
        chk("prio_recording", recording, 1'b1);
        chk("prio_playing", playing, 1'b0);
        chk("prio_mem_full_clr", mem_full, 1'b0);
        play_req = 1'b1;
        step(1);
        play_req = 1'b0;
        chk("rec_play_ignored", playing, 1'b0);
        rec_req = 1'b1;
        step(1);
        rec_req = 1'b0;
        chk("empty_stop_recording", recording, 1'b0);
        chk("empty_stop_rec_len", rec_len, 0);
        play_req = 1'b1;
        step(1);
        play_req = 1'b0;
        chk("empty_play_ignored", playing, 1'b0);
        step(2);
        chk("empty_play_still_idle", playing, 1'b0);

        // Asynchronous reset in the middle of playback.
        pats[0] = 7'h7E; pats[1] = 7'h7E;
        record(2, 1'b1);
        chk("rst_pre_rec_len", rec_len, 1);
        play_req = 1'b1;
        step(1);
        play_req = 1'b0;
        step(4);
        chk("rst_pre_btn_out", btn_out, 7'h7E);
        chk("rst_pre_playing", playing, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_btn_out", btn_out, 7'h7F);
        chk("async_rst_playing", playing, 1'b0);
        chk("async_rst_rec_len", rec_len, 0);
        chk("async_rst_recording", recording, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3);
        chk("post_rst_playing", playing, 1'b0);
        chk("post_rst_btn_out", btn_out, 7'h7F);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
